dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters: port 0 is the core's M-stage load/store path, port 1 is a loader/DMA engine.
- Runs a round-robin grant with at most one transaction in flight, and sequences the memory latency.
- Rejects misaligned accesses without touching memory.
- Sits between the core/loader and the data memory, and drives the memory's enable, write, size, address and write-data pins.

Parameters:
- MEM_LAT, 1: memory read latency in cycles from mem_en to valid mem_rdata. Legal range 1..4.
- AW, 32: requester byte-address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle
- req0_write  in  1  1 = store, 0 = load
- req0_size  in  3  funct3 size code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req0_addr  in  AW  byte address
- req0_wdata  in  32  store data
- resp0_valid  out  1  one-cycle response pulse
- resp0_rdata  out  32  load data; 0 for stores and errors
- resp0_err  out  1  misaligned access, qualified by resp0_valid
- req1_*/resp1_*  same set as port 0, for port 1
- mem_en  out  1  memory access strobe
- mem_write  out  1  memory write enable, only with mem_en
- mem_size  out  3  size code passed through
- mem_addr  out  AW  byte address
- mem_wdata  out  32  store data
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Reset:
  - state=IDLE, last_grant=1 (so port 0 wins the first tie).
  - All ready, resp, err and mem_* outputs are 0.
  - Latency counter is 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - reqN_ready = 1 for the granted port only, combinationally from valid.
  - Grant rule: if exactly one port is valid, it wins. If both are valid, the port != last_grant wins.
  - On handshake: latch write, size, addr, wdata and port id into the txn registers; update last_grant.
  - Aligned request -> ISSUE. Misaligned request (w with addr[1:0]!=0; h/hu with addr[0]!=0) -> RESP with err=1.
  - No handshake -> stay in IDLE.
- ISSUE: one cycle. mem_en=1, mem_* driven from the txn registers. Counter loads MEM_LAT-1. Next state is WAIT if MEM_LAT>1, else RESP.
- WAIT: counter decrements each cycle. On counter==1 -> RESP. mem_en=0.
- RESP: one cycle.
  - resp<id>_valid=1.
  - resp<id>_rdata = mem_rdata for loads; 0 for stores and errors.
  - Next state IDLE.
  - The non-granted port's resp_valid stays 0.
- ready is 0 in every state except IDLE, so at most one transaction is outstanding.
- Timing for an aligned access with handshake in cycle t:
  - mem_en in cycle t+1.
  - resp_valid in cycle t+1+MEM_LAT.
  - Earliest next handshake in cycle t+2+MEM_LAT.
- Timing for a misaligned access with handshake in cycle t: resp_valid with err=1 in cycle t+1; mem_en is never asserted.
- Requesters must hold valid and fields stable until ready. A valid dropped before ready is legal and issues nothing.
- Simultaneous valid on both ports: the loser stays pending and is granted in the next IDLE cycle, so neither port can starve.
- Reset in any state (mid-transaction included):
  - Next cycle is IDLE with reset values.
  - The pending response is dropped; a store whose ISSUE cycle has already occurred stays committed in memory.
- mem_* outputs are 0 outside ISSUE.
- The arbiter never forwards an unlatched requester field to memory.

Decomposition:
- Shared package `dmem_pkg`:
  - Size-code localparams SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU.
  - FSM state enum.
  - Struct mem_txn_t {write, size, addr, wdata, id}.
- The misalignment check is a function in `dmem_pkg`, reused by the core's exception logic.
- One natural sub-module: `rr_arb2`, a 2-way round-robin grant holding last_grant, with inputs req[1:0] and accept, and output gnt[1:0].

Test Plan:
- Single load: reset, then port 0 load w at 0x100 with mem_rdata=0xDEADBEEF, MEM_LAT=1 -> req0_ready in cycle t, mem_en with mem_addr=0x100 in t+1, resp0_valid with rdata=0xDEADBEEF in t+2; port 1 sees no response.
- Tie and round-robin: both ports hold valid for 4 transactions -> grants in order 0,1,0,1, one every MEM_LAT+2 cycles; each resp lands on the correct port.
- Store ack: port 1 store b at 0x203, wdata=0xAB -> mem_write=1, mem_size=000, mem_addr=0x203 in t+1; resp1_valid with rdata=0 and err=0 at t+2.
- Misalign: port 0 load h at 0x101 -> resp0_valid with err=1 at t+1, mem_en stays 0; likewise w at 0x102.
- Latency sweep: MEM_LAT=3, load at 0x40 -> resp at t+4 with rdata from mem_rdata at that cycle; ready stays 0 for cycles t+1..t+4.
- Reset mid-flight: assert reset in the WAIT cycle (MEM_LAT=3) -> no resp pulse; next cycle is IDLE; a subsequent tie grants port 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
//  Module   : dmem_pkg
//  Brief    : Shared types, size codes and alignment check for the data-memory
//             arbiter and the core's exception logic.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    // funct3 access-size codes
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    // Address width held in the transaction record
    localparam int DMEM_AW = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic               write;
        logic [2:0]         size;
        logic [DMEM_AW-1:0] addr;
        logic [31:0]        wdata;
        logic               id;
    } mem_txn_t;

    // Halfwords need an even address, words a multiple of four; bytes never fault.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        logic w_mis;
        w_mis = 1'b0;
        case (size)
            SZ_H, SZ_HU: w_mis = addr_lo[0];
            SZ_W:        w_mis = |addr_lo;
            default:     w_mis = 1'b0;
        endcase
        return w_mis;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
//  Module   : dmem_arbiter_if
//  Brief    : Requester (two ports) and data-memory bus bundle of the arbiter.
//             slave = arbiter side, master = requesters + memory side.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
    parameter int AW = 32
);
    logic          req0_valid;
    logic          req0_ready;
    logic          req0_write;
    logic [2:0]    req0_size;
    logic [AW-1:0] req0_addr;
    logic [31:0]   req0_wdata;
    logic          resp0_valid;
    logic [31:0]   resp0_rdata;
    logic          resp0_err;

    logic          req1_valid;
    logic          req1_ready;
    logic          req1_write;
    logic [2:0]    req1_size;
    logic [AW-1:0] req1_addr;
    logic [31:0]   req1_wdata;
    logic          resp1_valid;
    logic [31:0]   resp1_rdata;
    logic          resp1_err;

    logic          mem_en;
    logic          mem_write;
    logic [2:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  req0_valid, req0_write, req0_size, req0_addr, req0_wdata,
        output req0_ready, resp0_valid, resp0_rdata, resp0_err,
        input  req1_valid, req1_write, req1_size, req1_addr, req1_wdata,
        output req1_ready, resp1_valid, resp1_rdata, resp1_err,
        output mem_en, mem_write, mem_size, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req0_valid, req0_write, req0_size, req0_addr, req0_wdata,
        input  req0_ready, resp0_valid, resp0_rdata, resp0_err,
        output req1_valid, req1_write, req1_size, req1_addr, req1_wdata,
        input  req1_ready, resp1_valid, resp1_rdata, resp1_err,
        input  mem_en, mem_write, mem_size, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
// ============================================================================
//  Module   : rr_arb2
//  Brief    : Two-way round-robin grant. A lone requester always wins; on a
//             tie the port that was not granted last wins.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic r_last_grant;

    // Grant decode from the current requests and the last winner
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Remember the winner of each accepted grant; reset favours port 0
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (accept) begin
            r_last_grant <= gnt[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
//  Module   : dmem_arbiter
//  Brief    : Shares a single-port synchronous data memory between the core
//             M-stage (port 0) and a loader/DMA (port 1). One transaction in
//             flight, round-robin grant, misaligned accesses answered with err
//             without touching memory.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    import dmem_pkg::*;

    localparam logic [2:0] c_LAT_M1 = 3'(MEM_LAT - 1);

    state_t        r_state;
    mem_txn_t      r_txn;
    logic [2:0]    r_cnt;
    logic          r_mem_en;
    logic [1:0]    r_resp_valid;
    logic          r_resp_err;

    logic [1:0]    w_req;
    logic [1:0]    w_gnt;
    logic          w_idle;
    logic          w_accept;
    logic          w_sel;
    logic          w_write;
    logic [2:0]    w_size;
    logic [AW-1:0] w_addr;
    logic [31:0]   w_wdata;
    logic          w_mis;
    logic [31:0]   w_rdata;

    assign w_req    = {bus.req1_valid, bus.req0_valid};
    // Ready is held low while reset is asserted so nothing is accepted then
    assign w_idle   = (r_state == ST_IDLE) && !reset;
    assign w_accept = w_idle && (|w_req);

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .reset  (reset),
        .req    (w_req),
        .accept (w_accept),
        .gnt    (w_gnt)
    );

    // Fields of the granted requester, only ever used to load the txn record
    assign w_sel   = w_gnt[1];
    assign w_write = w_sel ? bus.req1_write : bus.req0_write;
    assign w_size  = w_sel ? bus.req1_size  : bus.req0_size;
    assign w_addr  = w_sel ? bus.req1_addr  : bus.req0_addr;
    assign w_wdata = w_sel ? bus.req1_wdata : bus.req0_wdata;
    assign w_mis   = is_misaligned(w_size, w_addr[1:0]);

    assign bus.req0_ready = w_idle & w_gnt[0];
    assign bus.req1_ready = w_idle & w_gnt[1];

    // Memory pins come only from the latched record and are zero outside ISSUE
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_write = r_mem_en & r_txn.write;
    assign bus.mem_size  = r_mem_en ? r_txn.size        : 3'b000;
    assign bus.mem_addr  = r_mem_en ? AW'(r_txn.addr)   : '0;
    assign bus.mem_wdata = r_mem_en ? r_txn.wdata       : 32'h0;

    // Load data arrives in the RESP cycle, so it is passed straight through
    assign w_rdata = (!r_txn.write && !r_resp_err) ? bus.mem_rdata : 32'h0;

    assign bus.resp0_valid = r_resp_valid[0];
    assign bus.resp0_rdata = r_resp_valid[0] ? w_rdata : 32'h0;
    assign bus.resp0_err   = r_resp_valid[0] & r_resp_err;
    assign bus.resp1_valid = r_resp_valid[1];
    assign bus.resp1_rdata = r_resp_valid[1] ? w_rdata : 32'h0;
    assign bus.resp1_err   = r_resp_valid[1] & r_resp_err;

    // Transaction sequencer: accept, issue, wait out the latency, respond
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_txn        <= '0;
            r_cnt        <= 3'd0;
            r_mem_en     <= 1'b0;
            r_resp_valid <= 2'b00;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_txn.write <= w_write;
                        r_txn.size  <= w_size;
                        r_txn.addr  <= DMEM_AW'(w_addr);
                        r_txn.wdata <= w_wdata;
                        r_txn.id    <= w_sel;
                        if (w_mis) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= {w_sel, !w_sel};
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state  <= ST_ISSUE;
                            r_mem_en <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_mem_en <= 1'b0;
                    r_cnt    <= c_LAT_M1;
                    if (MEM_LAT > 1) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= {r_txn.id, !r_txn.id};
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= {r_txn.id, !r_txn.id};
                    end
                end
                ST_RESP: begin
                    r_resp_valid <= 2'b00;
                    r_resp_err   <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Brief    : Directed bench for dmem_arbiter with a response scoreboard.
//             Two instances: MEM_LAT=1 and MEM_LAT=3.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst1 = 1'b1;
    logic rst3 = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   ne1 = 0, ne3 = 0, exp_en1 = 0, exp_en3 = 0;

    exp_t q1[$];
    exp_t q3[$];
    logic [31:0] m1 [logic [31:0]];
    logic [31:0] m3 [logic [31:0]];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter_if #(.AW(32)) bus1 ();
    dmem_arbiter_if #(.AW(32)) bus3 ();

    dmem_arbiter #(.MEM_LAT(1), .AW(32)) u_dut1 (.clk(clk), .reset(rst1), .bus(bus1));
    dmem_arbiter #(.MEM_LAT(3), .AW(32)) u_dut3 (.clk(clk), .reset(rst3), .bus(bus3));

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic mis(input logic [2:0] sz, input logic [31:0] a);
        if (sz == 3'b010) return a[1:0] != 2'b00;
        if (sz == 3'b001 || sz == 3'b101) return a[0];
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_vec++;
        n_err++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    function automatic exp_t mk_exp(input int port, input logic wr, input logic [2:0] sz,
                                     input logic [31:0] a, input logic [31:0] memv, input int lat);
        exp_t e;
        e.port = port;
        if (mis(sz, a)) begin
            e.rdata = 32'h0; e.err = 1'b1; e.cyc = cyc + 1;
        end else begin
            e.rdata = wr ? 32'h0 : memv; e.err = 1'b0; e.cyc = cyc + 1 + lat;
        end
        return e;
    endfunction

    // Memory models: stores commit at the ISSUE edge, load data after MEM_LAT cycles
    logic [31:0] p3a, p3b;
    always @(posedge clk) begin
        if (bus1.mem_en && bus1.mem_write) m1[bus1.mem_addr] = bus1.mem_wdata;
        bus1.mem_rdata <= (bus1.mem_en && !bus1.mem_write) ?
            (m1.exists(bus1.mem_addr) ? m1[bus1.mem_addr] : dflt(bus1.mem_addr)) : 32'hBAD0_0001;
        if (bus3.mem_en && bus3.mem_write) m3[bus3.mem_addr] = bus3.mem_wdata;
        p3a <= (bus3.mem_en && !bus3.mem_write) ?
            (m3.exists(bus3.mem_addr) ? m3[bus3.mem_addr] : dflt(bus3.mem_addr)) : 32'hBAD0_0003;
        p3b <= p3a;
        bus3.mem_rdata <= p3b;
    end

    // Scoreboard for instance 1: push on handshake, pop on response
    always @(negedge clk) begin
        exp_t e;
        int   p;
        if (bus1.mem_en) ne1++;
        if (rst1) begin
            q1.delete();
        end else begin
            if (bus1.req0_valid && bus1.req0_ready) begin
                e = mk_exp(0, bus1.req0_write, bus1.req0_size, bus1.req0_addr,
                           m1.exists(bus1.req0_addr) ? m1[bus1.req0_addr] : dflt(bus1.req0_addr), 1);
                if (!e.err) exp_en1++;
                q1.push_back(e);
            end
            if (bus1.req1_valid && bus1.req1_ready) begin
                e = mk_exp(1, bus1.req1_write, bus1.req1_size, bus1.req1_addr,
                           m1.exists(bus1.req1_addr) ? m1[bus1.req1_addr] : dflt(bus1.req1_addr), 1);
                if (!e.err) exp_en1++;
                q1.push_back(e);
            end
            if (bus1.resp0_valid || bus1.resp1_valid) begin
                chk("m1_two_resp", {63'd0, bus1.resp0_valid & bus1.resp1_valid}, 64'd0);
                if (q1.size() == 0) begin
                    chk("m1_unexpected_resp", 64'(q1.size()), 64'd1);
                end else begin
                    e = q1.pop_front();
                    p = bus1.resp1_valid ? 1 : 0;
                    chk("m1_port",  64'(p), 64'(e.port));
                    chk("m1_rdata", p ? bus1.resp1_rdata : bus1.resp0_rdata, e.rdata);
                    chk("m1_err",   p ? bus1.resp1_err   : bus1.resp0_err,   e.err);
                    chk("m1_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    // Scoreboard for instance 3
    always @(negedge clk) begin
        exp_t e;
        int   p;
        if (bus3.mem_en) ne3++;
        if (rst3) begin
            q3.delete();
        end else begin
            if (bus3.req0_valid && bus3.req0_ready) begin
                e = mk_exp(0, bus3.req0_write, bus3.req0_size, bus3.req0_addr,
                           m3.exists(bus3.req0_addr) ? m3[bus3.req0_addr] : dflt(bus3.req0_addr), 3);
                if (!e.err) exp_en3++;
                q3.push_back(e);
            end
            if (bus3.req1_valid && bus3.req1_ready) begin
                e = mk_exp(1, bus3.req1_write, bus3.req1_size, bus3.req1_addr,
                           m3.exists(bus3.req1_addr) ? m3[bus3.req1_addr] : dflt(bus3.req1_addr), 3);
                if (!e.err) exp_en3++;
                q3.push_back(e);
            end
            if (bus3.resp0_valid || bus3.resp1_valid) begin
                chk("m3_two_resp", {63'd0, bus3.resp0_valid & bus3.resp1_valid}, 64'd0);
                if (q3.size() == 0) begin
                    chk("m3_unexpected_resp", 64'(q3.size()), 64'd1);
                end else begin
                    e = q3.pop_front();
                    p = bus3.resp1_valid ? 1 : 0;
                    chk("m3_port",  64'(p), 64'(e.port));
                    chk("m3_rdata", p ? bus3.resp1_rdata : bus3.resp0_rdata, e.rdata);
                    chk("m3_err",   p ? bus3.resp1_err   : bus3.resp0_err,   e.err);
                    chk("m3_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs1(input int port, output int t);
        int n;
        logic hit;
        n = 0; t = -1; hit = 1'b0;
        while (!hit && n < 20) begin
            @(negedge clk);
            hit = (port == 0) ? (bus1.req0_valid && bus1.req0_ready)
                              : (bus1.req1_valid && bus1.req1_ready);
            if (hit) t = cyc;
            n++;
        end
        if (!hit) timeout("hs1");
    endtask

    task automatic wait_hs3(input int port, output int t);
        int n;
        logic hit;
        n = 0; t = -1; hit = 1'b0;
        while (!hit && n < 20) begin
            @(negedge clk);
            hit = (port == 0) ? (bus3.req0_valid && bus3.req0_ready)
                              : (bus3.req1_valid && bus3.req1_ready);
            if (hit) t = cyc;
            n++;
        end
        if (!hit) timeout("hs3");
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q1.size() != 0 || q3.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q1.size() != 0 || q3.size() != 0) timeout("drain");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, prev, port, n;
        logic got;
        bus1.req0_valid = 0; bus1.req0_write = 0; bus1.req0_size = W; bus1.req0_addr = 0; bus1.req0_wdata = 0;
        bus1.req1_valid = 0; bus1.req1_write = 0; bus1.req1_size = W; bus1.req1_addr = 0; bus1.req1_wdata = 0;
        bus3.req0_valid = 0; bus3.req0_write = 0; bus3.req0_size = W; bus3.req0_addr = 0; bus3.req0_wdata = 0;
        bus3.req1_valid = 0; bus3.req1_write = 0; bus3.req1_size = W; bus3.req1_addr = 0; bus3.req1_wdata = 0;
        m1[32'h100] = 32'hDEAD_BEEF;

        // Reset state, with a request pending that must not be accepted
        bus1.req0_valid = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", bus1.req0_ready, 0);
        chk("rst_mem_en", bus1.mem_en, 0);
        chk("rst_resp0",  bus1.resp0_valid, 0);
        chk("rst_err0",   bus1.resp0_err, 0);
        chk("rst_addr",   bus1.mem_addr, 0);
        step();
        bus1.req0_valid = 0;
        rst1 = 0; rst3 = 0;

        // Single load, port 0, word at 0x100
        step();
        bus1.req0_valid = 1; bus1.req0_write = 0; bus1.req0_size = W; bus1.req0_addr = 32'h100;
        wait_hs1(0, t);
        chk("t1_ready1", bus1.req1_ready, 0);
        step();
        bus1.req0_valid = 0;
        @(negedge clk);
        chk("t1_mem_en",   bus1.mem_en, 1);
        chk("t1_mem_addr", bus1.mem_addr, 32'h100);
        chk("t1_mem_wr",   bus1.mem_write, 0);
        chk("t1_busy",     bus1.req0_ready, 0);
        @(negedge clk);
        chk("t1_resp0",  bus1.resp0_valid, 1);
        chk("t1_rdata",  bus1.resp0_rdata, 32'hDEAD_BEEF);
        chk("t1_resp1",  bus1.resp1_valid, 0);
        chk("t1_cycle",  64'(cyc - t), 64'd2);

        // Store byte, port 1
        step();
        bus1.req1_valid = 1; bus1.req1_write = 1; bus1.req1_size = B;
        bus1.req1_addr = 32'h203; bus1.req1_wdata = 32'hAB;
        wait_hs1(1, t);
        step();
        bus1.req1_valid = 0;
        @(negedge clk);
        chk("t3_mem_en",    bus1.mem_en, 1);
        chk("t3_mem_write", bus1.mem_write, 1);
        chk("t3_mem_size",  bus1.mem_size, B);
        chk("t3_mem_addr",  bus1.mem_addr, 32'h203);
        chk("t3_mem_wdata", bus1.mem_wdata, 32'hAB);
        @(negedge clk);
        chk("t3_resp1",  bus1.resp1_valid, 1);
        chk("t3_rdata",  bus1.resp1_rdata, 0);
        chk("t3_err",    bus1.resp1_err, 0);
        chk("t3_resp0",  bus1.resp0_valid, 0);

        // Tie: both ports hold valid for four grants
        step();
        bus1.req0_valid = 1; bus1.req0_write = 0; bus1.req0_size = W; bus1.req0_addr = 32'h10;
        bus1.req1_valid = 1; bus1.req1_write = 0; bus1.req1_size = W; bus1.req1_addr = 32'h20;
        prev = -1;
        for (int k = 0; k < 4; k++) begin
            n = 0; got = 1'b0; port = -1;
            while (!got && n < 20) begin
                @(negedge clk);
                if (bus1.req0_ready || bus1.req1_ready) begin
                    got = 1'b1;
                    port = bus1.req1_ready ? 1 : 0;
                    chk("tie_single", {63'd0, bus1.req0_ready & bus1.req1_ready}, 64'd0);
                end
                n++;
            end
            if (!got) timeout("tie_grant");
            chk("tie_order", 64'(port), 64'(k % 2));
            if (prev >= 0) chk("tie_gap", 64'(cyc - prev), 64'd3);
            prev = cyc;
        end
        step();
        bus1.req0_valid = 0; bus1.req1_valid = 0;
        drain();

        // Misaligned halfword then word, port 0
        step();
        bus1.req0_valid = 1; bus1.req0_write = 0; bus1.req0_size = H; bus1.req0_addr = 32'h101;
        wait_hs1(0, t);
        step();
        bus1.req0_valid = 0;
        @(negedge clk);
        chk("mis_h_resp", bus1.resp0_valid, 1);
        chk("mis_h_err",  bus1.resp0_err, 1);
        chk("mis_h_data", bus1.resp0_rdata, 0);
        chk("mis_h_men",  bus1.mem_en, 0);
        step();
        bus1.req0_valid = 1; bus1.req0_size = W; bus1.req0_addr = 32'h102;
        wait_hs1(0, t);
        step();
        bus1.req0_valid = 0;
        @(negedge clk);
        chk("mis_w_resp", bus1.resp0_valid, 1);
        chk("mis_w_err",  bus1.resp0_err, 1);
        chk("mis_w_men",  bus1.mem_en, 0);
        @(negedge clk);
        chk("mis_w_men2", bus1.mem_en, 0);
        drain();

        // Latency 3: load at 0x40, port 1 waits until the earliest slot
        step();
        bus3.req0_valid = 1; bus3.req0_write = 0; bus3.req0_size = W; bus3.req0_addr = 32'h40;
        wait_hs3(0, t);
        step();
        bus3.req0_valid = 0;
        bus3.req1_valid = 1; bus3.req1_write = 0; bus3.req1_size = W; bus3.req1_addr = 32'h44;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("lat_ready1", bus3.req1_ready, 0);
            chk("lat_ready0", bus3.req0_ready, 0);
            if (i == 1) chk("lat_mem_addr", bus3.mem_addr, 32'h40);
            if (i == 2) chk("lat_mem_en_off", bus3.mem_en, 0);
            if (i == 4) begin
                chk("lat_resp0", bus3.resp0_valid, 1);
                chk("lat_rdata", bus3.resp0_rdata, dflt(32'h40));
            end
        end
        @(negedge clk);
        chk("lat_next_hs", bus3.req1_ready, 1);
        step();
        bus3.req1_valid = 0;
        drain();

        // Reset during WAIT drops the response and restores port-0 priority
        step();
        bus3.req0_valid = 1; bus3.req0_size = W; bus3.req0_addr = 32'h48;
        wait_hs3(0, t);
        step();
        bus3.req0_valid = 0;
        @(negedge clk);
        chk("rmf_issue", bus3.mem_en, 1);
        step();
        rst3 = 1;
        @(negedge clk);
        chk("rmf_wait_men", bus3.mem_en, 0);
        step();
        rst3 = 0;
        @(negedge clk);
        chk("rmf_idle_men",  bus3.mem_en, 0);
        chk("rmf_idle_resp", bus3.resp0_valid, 0);
        step();
        bus3.req0_valid = 1; bus3.req0_addr = 32'h50;
        bus3.req1_valid = 1; bus3.req1_addr = 32'h54;
        @(negedge clk);
        chk("rmf_tie0", bus3.req0_ready, 1);
        chk("rmf_tie1", bus3.req1_ready, 0);
        step();
        bus3.req0_valid = 0; bus3.req1_valid = 0;
        drain();
        repeat (3) @(negedge clk);

        chk("end_q1", 64'(q1.size()), 64'd0);
        chk("end_q3", 64'(q3.size()), 64'd0);
        chk("end_mem_en1", 64'(ne1), 64'(exp_en1));
        chk("end_mem_en3", 64'(ne3), 64'(exp_en3));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
